// File: rtl/counter_pkg.sv
// Shared types and helpers for the prescaled mode counter.
package counter_pkg;

  // Counting mode as presented on mode_in.
  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  // Ceiling log2; clog2(1) = 0, callers clamp the width to at least 1 bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running 0..PRESCALE-1 counter producing a one-cycle clock enable.
module tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic restart,
  output logic tick
);
  import counter_pkg::*;

  localparam int unsigned  CW   = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          run_q;

  // Next prescaler value: restart or terminal count returns to zero.
  always_comb begin
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler state; run_q masks tick while reset is held (matters for PRESCALE == 1).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= 1'b1;
    end
  end

  assign tick = run_q & (cnt_q == LAST);

endmodule

// File: rtl/prescaled_mode_counter.sv
// Modulo counter with up/down/hold/bounce modes, load, wrap/saturate, and a built-in
// prescaler clock enable so everything runs on the single CLK.
module prescaled_mode_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 4194304,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN_set_mode,
  input  logic [1:0]       mode_in,
  input  logic             EN_load,
  input  logic [WIDTH-1:0] load_value,
  output logic             RDY_load,
  output logic [WIDTH-1:0] count_value,
  output logic             RDY_count_value,
  output logic             tick,
  output logic             wrap,
  output logic             dir_down
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic             rdy_q;
  mode_t            mode_q;
  mode_t            mode_d;
  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             tick_w;
  logic             do_load;
  logic             do_set_mode;
  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_wrap;

  assign do_load     = EN_load & rdy_q;
  assign do_set_mode = EN_set_mode & rdy_q;

  // A load restarts the prescaler so the next tick lands a full period later.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .restart(do_load),
    .tick   (tick_w)
  );

  // One tick's step for the current mode; all arithmetic stays inside 0..MODULUS-1.
  always_comb begin
    step_count = count_q;
    step_dir   = dir_q;
    step_wrap  = 1'b0;
    unique case (mode_q)
      MODE_UP: begin
        if (count_q == MAX_COUNT) begin
          if (!SATURATE) begin
            step_count = '0;
            step_wrap  = 1'b1;
          end
        end else begin
          step_count = count_q + WIDTH'(1);
        end
      end
      MODE_DOWN: begin
        if (count_q == '0) begin
          if (!SATURATE) begin
            step_count = MAX_COUNT;
            step_wrap  = 1'b1;
          end
        end else begin
          step_count = count_q - WIDTH'(1);
        end
      end
      MODE_HOLD: begin
        step_count = count_q;
      end
      MODE_BOUNCE: begin
        // Reversal steps away from the end in the same tick.
        if (!dir_q) begin
          if (count_q == MAX_COUNT) begin
            step_count = MAX_COUNT - WIDTH'(1);
            step_dir   = 1'b1;
            step_wrap  = 1'b1;
          end else begin
            step_count = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            step_count = WIDTH'(1);
            step_dir   = 1'b0;
            step_wrap  = 1'b1;
          end else begin
            step_count = count_q - WIDTH'(1);
          end
        end
      end
      default: begin
        step_count = count_q;
      end
    endcase
  end

  // Next state: load beats a coincident tick; set_mode applies alongside either.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    if (do_load) begin
      count_d = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
    end else if (tick_w) begin
      count_d = step_count;
      dir_d   = step_dir;
      wrap_d  = step_wrap;
    end
    if (do_set_mode) begin
      mode_d = mode_t'(mode_in);
      if (mode_t'(mode_in) == MODE_BOUNCE) begin
        dir_d = 1'b0;
      end
    end
  end

  // Counter, mode, direction, wrap pulse and ready state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q   <= 1'b0;
      mode_q  <= MODE_UP;
      dir_q   <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign RDY_load        = rdy_q;
  assign RDY_count_value = rdy_q;
  assign count_value     = count_q;
  assign tick            = tick_w;
  assign wrap            = wrap_q;
  assign dir_down        = dir_q;

endmodule
